// File: rtl/cv32e40x_pkg.sv
// Shared types for the CV32E40X XIF result path: the result entry layout and
// the result-buffer head-state encoding.
package cv32e40x_pkg;

    localparam int XIF_ID_WIDTH  = 4;
    localparam int XIF_RFW_WIDTH = 32;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0]  id;
        logic [4:0]               rd;
        logic [XIF_RFW_WIDTH-1:0] data;
    } xif_result_entry_t;

    typedef enum logic [1:0] {
        EMPTY       = 2'd0,
        WAIT_COMMIT = 2'd1,
        PRESENT     = 2'd2,
        DROP        = 2'd3
    } xif_rbuf_state_e;

endpackage

// File: rtl/cv32e40x_xif_commit_scoreboard.sv
// Per-id commit/kill flags. The lookup port reports the flags as they will be
// after this cycle's set, ignoring this cycle's clear (which only ever hits the departing id).
module cv32e40x_xif_commit_scoreboard
#(
    parameter int X_ID_WIDTH = 4
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_valid_i,
    input  logic [X_ID_WIDTH-1:0] set_id_i,
    input  logic                  set_kill_i,
    input  logic                  clr_valid_i,
    input  logic [X_ID_WIDTH-1:0] clr_id_i,
    input  logic [X_ID_WIDTH-1:0] lookup_id_i,
    output logic                  lookup_committed_o,
    output logic                  lookup_killed_o
);

    localparam int NUM_IDS = 2 ** X_ID_WIDTH;

    logic [NUM_IDS-1:0] committed_q, committed_d;
    logic [NUM_IDS-1:0] killed_q, killed_d;
    logic               set_hit;

    // Set is applied after clear so a same-cycle set for the same id wins.
    always_comb begin
        committed_d = committed_q;
        killed_d    = killed_q;
        if (clr_valid_i) begin
            committed_d[clr_id_i] = 1'b0;
            killed_d[clr_id_i]    = 1'b0;
        end
        if (set_valid_i) begin
            if (set_kill_i) begin
                killed_d[set_id_i] = 1'b1;
            end else begin
                committed_d[set_id_i] = 1'b1;
            end
        end
    end

    assign set_hit            = set_valid_i && (set_id_i == lookup_id_i);
    assign lookup_committed_o = committed_q[lookup_id_i] || (set_hit && !set_kill_i);
    assign lookup_killed_o    = killed_q[lookup_id_i] || (set_hit && set_kill_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            committed_q <= '0;
            killed_q    <= '0;
        end else begin
            committed_q <= committed_d;
            killed_q    <= killed_d;
        end
    end

endmodule

// File: rtl/cv32e40x_xif_result_buffer.sv
// In-order, commit-aware result FIFO feeding the XIF result interface.
// Optional zero-latency bypass when empty: define XIF_RESULT_BYPASS_EN.
//
// state       | meaning
// EMPTY       | no entry held
// WAIT_COMMIT | head present, neither committed nor killed yet
// PRESENT     | head committed, driven on result_* until accepted
// DROP        | head killed, popped this cycle without being shown
module cv32e40x_xif_result_buffer
    import cv32e40x_pkg::*;
#(
    parameter int X_ID_WIDTH  = XIF_ID_WIDTH,
    parameter int X_RFW_WIDTH = XIF_RFW_WIDTH,
    parameter int DEPTH       = 4
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fu_valid_i,
    output logic                     fu_ready_o,
    input  logic [X_ID_WIDTH-1:0]    fu_id_i,
    input  logic [4:0]               fu_rd_i,
    input  logic [X_RFW_WIDTH-1:0]   fu_data_i,
    input  logic                     commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]    commit_id_i,
    input  logic                     commit_kill_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [X_ID_WIDTH-1:0]    result_id_o,
    output logic [4:0]               result_rd_o,
    output logic [X_RFW_WIDTH-1:0]   result_data_o,
    output logic                     result_we_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [4:0]             rd;
        logic [X_RFW_WIDTH-1:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    xif_rbuf_state_e state_q, state_d;
    logic            result_valid_q, result_valid_d;
    entry_t          head_q, head_d;

    entry_t          fu_entry;
    entry_t          head_nxt;
    logic            push;
    logic            pop;
    logic            bypass;
    logic            sb_committed;
    logic            sb_killed;

    assign fu_entry   = '{id: fu_id_i, rd: fu_rd_i, data: fu_data_i};
    assign fu_ready_o = (count_q < DEPTH_C);
    assign pop        = ((state_q == PRESENT) && result_ready_i) || (state_q == DROP);

`ifdef XIF_RESULT_BYPASS_EN
    assign bypass = (count_q == '0) && fu_valid_i && sb_committed && result_ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign push = fu_valid_i && fu_ready_o && !bypass;

    // Entry that will sit at the head next cycle; when the FIFO drains to
    // nothing this cycle, that can only be the incoming FU result.
    always_comb begin
        if ((count_q - CW'(pop)) == '0) begin
            head_nxt = fu_entry;
        end else begin
            head_nxt = mem_q[rd_ptr_q + PW'(pop)];
        end
    end

    cv32e40x_xif_commit_scoreboard #(
        .X_ID_WIDTH (X_ID_WIDTH)
    ) u_scoreboard (
        .clk                (clk),
        .rst_n              (rst_n),
        .set_valid_i        (commit_valid_i),
        .set_id_i           (commit_id_i),
        .set_kill_i         (commit_kill_i),
        .clr_valid_i        (pop || bypass),
        .clr_id_i           (bypass ? fu_id_i : mem_q[rd_ptr_q].id),
        .lookup_id_i        (head_nxt.id),
        .lookup_committed_o (sb_committed),
        .lookup_killed_o    (sb_killed)
    );

    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = fu_entry;
        end

        state_d = WAIT_COMMIT;
        if (count_d == '0) begin
            state_d = EMPTY;
        end else if (sb_committed) begin
            state_d = PRESENT;
        end else if (sb_killed) begin
            state_d = DROP;
        end

        result_valid_d = (state_d == PRESENT);
        head_d         = (count_d == '0) ? '0 : head_nxt;
    end

    always_comb begin
        result_valid_o = result_valid_q;
        result_id_o    = head_q.id;
        result_rd_o    = head_q.rd;
        result_data_o  = head_q.data;
`ifdef XIF_RESULT_BYPASS_EN
        if (bypass) begin
            result_valid_o = 1'b1;
            result_id_o    = fu_id_i;
            result_rd_o    = fu_rd_i;
            result_data_o  = fu_data_i;
        end
`endif
    end

    assign result_we_o = result_valid_o;
    assign count_o     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            state_q        <= EMPTY;
            result_valid_q <= 1'b0;
            head_q         <= '0;
        end else begin
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            state_q        <= state_d;
            result_valid_q <= result_valid_d;
            head_q         <= head_d;
        end
    end

endmodule

// File: tb/tb_cv32e40x_xif_result_buffer.sv
// Bench for the XIF result buffer: directed stimulus queues expected results,
// a negedge monitor pops and compares every accepted result.
module tb_cv32e40x_xif_result_buffer;

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        fu_valid_i;
    logic        fu_ready_o;
    logic [3:0]  fu_id_i;
    logic [4:0]  fu_rd_i;
    logic [31:0] fu_data_i;
    logic        commit_valid_i;
    logic [3:0]  commit_id_i;
    logic        commit_kill_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic [31:0] result_data_o;
    logic        result_we_o;
    logic [2:0]  count_o;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    cv32e40x_xif_result_buffer #(
        .X_ID_WIDTH  (4),
        .X_RFW_WIDTH (32),
        .DEPTH       (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fu_valid_i     (fu_valid_i),
        .fu_ready_o     (fu_ready_o),
        .fu_id_i        (fu_id_i),
        .fu_rd_i        (fu_rd_i),
        .fu_data_i      (fu_data_i),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (commit_id_i),
        .commit_kill_i  (commit_kill_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_id_o    (result_id_o),
        .result_rd_o    (result_rd_o),
        .result_data_o  (result_data_o),
        .result_we_o    (result_we_o),
        .count_o        (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] data,
                        input logic expect_out);
        fu_valid_i = 1'b1;
        fu_id_i    = id;
        fu_rd_i    = rd;
        fu_data_i  = data;
        if (expect_out) exp_q.push_back('{id: id, rd: rd, data: data});
        step();
        fu_valid_i = 1'b0;
    endtask

    task automatic commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
        step();
        commit_valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (result_we_o !== result_valid_o) begin
                n_cmp++;
                n_err++;
                $display("FAIL we_eq_valid: got we=%0b expected %0b", result_we_o, result_valid_o);
            end
            if (result_valid_o && result_ready_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_result: got id=%0h expected no result", result_id_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (result_id_o !== e.id || result_rd_o !== e.rd || result_data_o !== e.data) begin
                        n_err++;
                        $display("FAIL result_order: got id=%0h rd=%0h data=%0h expected id=%0h rd=%0h data=%0h",
                                 result_id_o, result_rd_o, result_data_o, e.id, e.rd, e.data);
                    end
                end
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        fu_valid_i     = 1'b0;
        fu_id_i        = '0;
        fu_rd_i        = '0;
        fu_data_i      = '0;
        commit_valid_i = 1'b0;
        commit_id_i    = '0;
        commit_kill_i  = 1'b0;
        result_ready_i = 1'b1;

        #12;
        chk("rst_valid", 32'(result_valid_o), 32'd0);
        chk("rst_we",    32'(result_we_o),    32'd0);
        chk("rst_count", 32'(count_o),        32'd0);
        chk("rst_id",    32'(result_id_o),    32'd0);
        chk("rst_data",  result_data_o,       32'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(fu_ready_o), 32'd1);

        // Commit before result: visible one cycle after the push.
        commit(4'd3, 1'b0);
        step();
        step();
        push(4'd3, 5'd5, 32'hDEADBEEF, 1'b1);
        chk("t1_valid", 32'(result_valid_o), 32'd1);
        chk("t1_id",    32'(result_id_o),    32'd3);
        chk("t1_rd",    32'(result_rd_o),    32'd5);
        chk("t1_data",  result_data_o,       32'hDEADBEEF);
        chk("t1_we",    32'(result_we_o),    32'd1);
        step();
        chk("t1_count_after", 32'(count_o), 32'd0);

        // Result then kill: dropped, never presented.
        push(4'd7, 5'd1, 32'h0000_0777, 1'b0);
        step();
        step();
        chk("t2_wait_valid", 32'(result_valid_o), 32'd0);
        commit(4'd7, 1'b1);
        chk("t2_drop_count", 32'(count_o), 32'd1);
        chk("t2_drop_valid", 32'(result_valid_o), 32'd0);
        step();
        chk("t2_count_zero", 32'(count_o), 32'd0);

        // Backpressure with a full buffer.
        result_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) commit(4'(i), 1'b0);
        for (int i = 0; i < 4; i++) push(4'(i), 5'(10 + i), 32'h1000_0000 + 32'(i), 1'b1);
        chk("t3_count_full", 32'(count_o),        32'd4);
        chk("t3_not_ready",  32'(fu_ready_o),     32'd0);
        chk("t3_valid_held", 32'(result_valid_o), 32'd1);
        chk("t3_id_held",    32'(result_id_o),    32'd0);
        fu_valid_i = 1'b1;
        fu_id_i    = 4'd9;
        step();
        step();
        fu_valid_i = 1'b0;
        chk("t3_push_blocked", 32'(count_o),     32'd4);
        chk("t3_id_stable",    32'(result_id_o), 32'd0);
        chk("t3_data_stable",  result_data_o,    32'h1000_0000);
        result_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain_valid", 32'(result_valid_o), 32'd1);
            chk("t3_drain_id",    32'(result_id_o),    32'(i));
            step();
        end
        chk("t3_empty_count", 32'(count_o),        32'd0);
        chk("t3_empty_valid", 32'(result_valid_o), 32'd0);

        // Mixed: kill younger id, commit older id.
        push(4'd1, 5'd2, 32'hAAAA_0001, 1'b1);
        push(4'd2, 5'd3, 32'hAAAA_0002, 1'b0);
        commit(4'd2, 1'b1);
        chk("t4_head_waits", 32'(result_valid_o), 32'd0);
        commit(4'd1, 1'b0);
        chk("t4_commit_lat", 32'(result_valid_o), 32'd1);
        chk("t4_id",         32'(result_id_o),    32'd1);
        step();
        chk("t4_drop_valid", 32'(result_valid_o), 32'd0);
        chk("t4_drop_count", 32'(count_o),        32'd1);
        step();
        chk("t4_count_zero", 32'(count_o), 32'd0);

        // Wrap-around: ten pushes committed in the same cycle, random ready.
        begin
            int sent = 0;
            int cyc  = 0;
            while (sent < 10 && cyc < 300) begin
                result_ready_i = 1'($urandom_range(0, 1));
                if (fu_ready_o) begin
                    fu_valid_i     = 1'b1;
                    fu_id_i        = 4'(sent);
                    fu_rd_i        = 5'(sent + 1);
                    fu_data_i      = 32'hA5A5_0000 + 32'(sent);
                    commit_valid_i = 1'b1;
                    commit_id_i    = 4'(sent);
                    commit_kill_i  = 1'b0;
                    exp_q.push_back('{id: 4'(sent), rd: 5'(sent + 1), data: 32'hA5A5_0000 + 32'(sent)});
                    sent++;
                end
                step();
                fu_valid_i     = 1'b0;
                commit_valid_i = 1'b0;
                cyc++;
            end
            chk("t5_all_sent", 32'(sent), 32'd10);
            result_ready_i = 1'b1;
            cyc = 0;
            while (count_o != 3'd0 && cyc < 50) begin
                step();
                cyc++;
            end
            chk("t5_drained", 32'(count_o), 32'd0);
            chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        // Reset in the middle of traffic.
        result_ready_i = 1'b0;
        commit(4'd10, 1'b0);
        push(4'd10, 5'd4, 32'hBBBB_0010, 1'b0);
        push(4'd11, 5'd4, 32'hBBBB_0011, 1'b0);
        push(4'd12, 5'd4, 32'hBBBB_0012, 1'b0);
        commit(4'd13, 1'b0);
        chk("t6_pre_count", 32'(count_o),        32'd3);
        chk("t6_pre_valid", 32'(result_valid_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(result_valid_o), 32'd0);
        chk("t6_rst_count", 32'(count_o),        32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        result_ready_i = 1'b1;
        step();
        push(4'd13, 5'd6, 32'hCCCC_0013, 1'b0);
        step();
        chk("t6_stale_commit", 32'(result_valid_o), 32'd0);
        chk("t6_waiting",      32'(count_o),        32'd1);
        commit(4'd13, 1'b1);
        step();
        chk("t6_cleanup", 32'(count_o), 32'd0);

        step();
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
